// File: rtl/sr_ff_driver_if.sv
// rtl/sr_ff_driver_if.sv - target-bit stream, S/R drive and check-result bundle for sr_ff_driver
interface sr_ff_driver_if #(
    parameter int CNT_W = 8
);
    logic             D_IN;
    logic             D_VALID;
    logic             D_READY;
    logic             S;
    logic             R;
    logic             Q_FB;
    logic             QBAR_FB;
    logic             DONE;
    logic             MATCH;
    logic             ERR;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] XFER_CNT;

    modport master (
        output D_IN, D_VALID, Q_FB, QBAR_FB,
        input  D_READY, S, R, DONE, MATCH, ERR, ERR_CNT, XFER_CNT
    );

    modport slave (
        input  D_IN, D_VALID, Q_FB, QBAR_FB,
        output D_READY, S, R, DONE, MATCH, ERR, ERR_CNT, XFER_CNT
    );
endinterface

// File: rtl/sr_ff_driver.sv
// rtl/sr_ff_driver.sv - converts target Q bits into one-cycle S/R pulses and checks the flop response
module sr_ff_driver #(
    parameter int CNT_W = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    sr_ff_driver_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             pass;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            tgt_q      <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            match_q    <= match_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        s_d        = s_q;
        r_d        = r_q;
        done_d     = 1'b0;
        match_d    = match_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        pass       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                if (bus.D_VALID) begin
                    tgt_d   = bus.D_IN;
                    // Only drive when the target differs from current Q, so S and R are never both set
                    s_d     = bus.D_IN & ~bus.Q_FB;
                    r_d     = ~bus.D_IN & bus.Q_FB;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                pass    = (bus.Q_FB == tgt_q) && (bus.QBAR_FB != bus.Q_FB);
                match_d = pass;
                done_d  = 1'b1;
                if (xfer_cnt_q != CNT_MAX) xfer_cnt_d = xfer_cnt_q + 1'b1;
                if (!pass) begin
                    err_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.D_READY  = (state_q == ST_IDLE);
    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.DONE     = done_q;
    assign bus.MATCH    = match_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CNT  = err_cnt_q;
    assign bus.XFER_CNT = xfer_cnt_q;
endmodule

// File: tb/tb_sr_ff_driver.sv
// tb/tb_sr_ff_driver.sv - self-checking bench for sr_ff_driver with a behavioural SR flop model
module tb_sr_ff_driver;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    sr_ff_driver_if #(.CNT_W(8)) bus ();
    sr_ff_driver_if #(.CNT_W(2)) sbus ();

    sr_ff_driver #(.CNT_W(8)) dut     (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    sr_ff_driver #(.CNT_W(2)) dut_sat (.CLK(CLK), .RST_N(RST_N), .bus(sbus));

    int total = 0;
    int bad   = 0;

    // Flop under test: stuck forces Q low, incons forces Qbar high
    logic q_flop = 1'b0;
    logic stuck  = 1'b0;
    logic incons = 1'b0;

    always @(posedge CLK) begin
        if (stuck)                    q_flop <= 1'b0;
        else if (bus.S && !bus.R)     q_flop <= 1'b1;
        else if (bus.R && !bus.S)     q_flop <= 1'b0;
    end

    assign bus.Q_FB     = stuck ? 1'b0 : q_flop;
    assign bus.QBAR_FB  = incons ? 1'b1 : ~bus.Q_FB;
    assign sbus.Q_FB    = 1'b0;
    assign sbus.QBAR_FB = 1'b1;

    always @(negedge CLK) begin
        total = total + 1;
        if (((bus.S & bus.R) | (sbus.S & sbus.R)) !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL sr_exclusive t=%0t S=%b R=%b sat_S=%b sat_R=%b required not both 1",
                     $time, bus.S, bus.R, sbus.S, sbus.R);
        end
    end

    typedef struct packed {
        logic s0, r0, rdy0;
        logic s1, r1, rdy1, done1;
        logic done2, match2, rdy2;
        logic to;
    } obs_t;

    // Sends one target bit starting at a negedge; returns at the negedge of the DONE cycle
    task automatic run_xfer(input logic t, input logic keep_valid, output obs_t o);
        int n;
        o = '0;
        bus.D_IN    = t;
        bus.D_VALID = 1'b1;
        n = 0;
        while (bus.D_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) begin
            o.to = 1'b1;
            bus.D_VALID = 1'b0;
            return;
        end
        @(negedge CLK);
        o.s0 = bus.S; o.r0 = bus.R; o.rdy0 = bus.D_READY;
        bus.D_IN    = ~t;
        bus.D_VALID = keep_valid;
        @(negedge CLK);
        o.s1 = bus.S; o.r1 = bus.R; o.rdy1 = bus.D_READY; o.done1 = bus.DONE;
        @(negedge CLK);
        o.done2 = bus.DONE; o.match2 = bus.MATCH; o.rdy2 = bus.D_READY;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        RST_N        = 1'b0;
        bus.D_VALID  = 1'b0;
        sbus.D_VALID = 1'b0;
        repeat (cycles) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if ({bus.S, bus.R, bus.D_READY, bus.DONE, bus.MATCH, bus.ERR} !== 6'b001000) begin
            bad++;
            $display("FAIL reset_outputs S,R,RDY,DONE,MATCH,ERR=%b required 001000",
                     {bus.S, bus.R, bus.D_READY, bus.DONE, bus.MATCH, bus.ERR});
        end
        total++;
        if ({bus.ERR_CNT, bus.XFER_CNT} !== 16'h0) begin
            bad++;
            $display("FAIL reset_counters err=%0d xfer=%0d required 0 0", bus.ERR_CNT, bus.XFER_CNT);
        end
    endtask

    task automatic test_set();
        obs_t o;
        run_xfer(1'b1, 1'b0, o);
        total++;
        if ({o.to, o.s0, o.r0, o.rdy0} !== 4'b0100) begin
            bad++;
            $display("FAIL set_drive to,S,R,RDY=%b required 0100", {o.to, o.s0, o.r0, o.rdy0});
        end
        total++;
        if ({o.s1, o.r1, o.rdy1, o.done1} !== 4'b0000) begin
            bad++;
            $display("FAIL set_check_cycle S,R,RDY,DONE=%b required 0000", {o.s1, o.r1, o.rdy1, o.done1});
        end
        total++;
        if ({o.done2, o.match2, o.rdy2} !== 3'b111) begin
            bad++;
            $display("FAIL set_done DONE,MATCH,RDY=%b required 111", {o.done2, o.match2, o.rdy2});
        end
        total++;
        if (bus.XFER_CNT !== 8'd1 || bus.ERR_CNT !== 8'd0) begin
            bad++;
            $display("FAIL set_counters xfer=%0d err=%0d required 1 0", bus.XFER_CNT, bus.ERR_CNT);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [2:0] tv;
        logic [5:0] srv;
        do_reset(1);
        tv  = 3'b001;
        srv = 6'b01_00_10;
        for (int i = 0; i < 3; i++) begin
            run_xfer(tv[2-i], 1'b1, o);
            total++;
            if ({o.to, o.s0, o.r0} !== {1'b0, srv[5-2*i -: 2]}) begin
                bad++;
                $display("FAIL b2b_sr[%0d] to,S,R=%b required 0%b", i, {o.to, o.s0, o.r0}, srv[5-2*i -: 2]);
            end
            total++;
            if ({o.rdy0, o.rdy1, o.rdy2, o.done1, o.done2, o.match2} !== 6'b001011) begin
                bad++;
                $display("FAIL b2b_ready_done[%0d] rdy0,rdy1,rdy2,done1,done2,match=%b required 001011",
                         i, {o.rdy0, o.rdy1, o.rdy2, o.done1, o.done2, o.match2});
            end
        end
        bus.D_VALID = 1'b0;
        total++;
        if (bus.XFER_CNT !== 8'd3 || bus.ERR !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count xfer=%0d err=%b required 3 0", bus.XFER_CNT, bus.ERR);
        end
    endtask

    task automatic test_stuck();
        obs_t o;
        do_reset(1);
        stuck = 1'b1;
        run_xfer(1'b1, 1'b0, o);
        total++;
        if ({o.to, o.s0, o.r0, o.done2, o.match2, bus.ERR} !== 6'b010101) begin
            bad++;
            $display("FAIL stuck_fail to,S,R,DONE,MATCH,ERR=%b required 010101",
                     {o.to, o.s0, o.r0, o.done2, o.match2, bus.ERR});
        end
        total++;
        if (bus.ERR_CNT !== 8'd1) begin
            bad++;
            $display("FAIL stuck_errcnt got=%0d required 1", bus.ERR_CNT);
        end
        run_xfer(1'b0, 1'b0, o);
        total++;
        if ({o.to, o.done2, o.match2, bus.ERR} !== 4'b0111 || bus.ERR_CNT !== 8'd1 || bus.XFER_CNT !== 8'd2) begin
            bad++;
            $display("FAIL stuck_recover to,DONE,MATCH,ERR=%b err=%0d xfer=%0d required 0111 1 2",
                     {o.to, o.done2, o.match2, bus.ERR}, bus.ERR_CNT, bus.XFER_CNT);
        end
        stuck = 1'b0;
    endtask

    task automatic test_incons();
        obs_t o;
        do_reset(1);
        incons = 1'b1;
        run_xfer(1'b1, 1'b0, o);
        incons = 1'b0;
        total++;
        if ({o.to, o.done2, o.match2, bus.ERR} !== 4'b0101 || bus.ERR_CNT !== 8'd1) begin
            bad++;
            $display("FAIL incons to,DONE,MATCH,ERR=%b err=%0d required 0101 1",
                     {o.to, o.done2, o.match2, bus.ERR}, bus.ERR_CNT);
        end
    endtask

    task automatic test_reset_mid();
        // flop holds 1 here, so target 0 drives R
        bus.D_IN    = 1'b0;
        bus.D_VALID = 1'b1;
        @(negedge CLK);
        total++;
        if ({bus.S, bus.R, bus.D_READY} !== 3'b010) begin
            bad++;
            $display("FAIL midrst_drive S,R,RDY=%b required 010", {bus.S, bus.R, bus.D_READY});
        end
        bus.D_VALID = 1'b0;
        RST_N       = 1'b0;
        @(negedge CLK);
        total++;
        if ({bus.S, bus.R, bus.D_READY, bus.DONE, bus.ERR} !== 5'b00100 || {bus.ERR_CNT, bus.XFER_CNT} !== 16'h0) begin
            bad++;
            $display("FAIL midrst_state S,R,RDY,DONE,ERR=%b err=%0d xfer=%0d required 00100 0 0",
                     {bus.S, bus.R, bus.D_READY, bus.DONE, bus.ERR}, bus.ERR_CNT, bus.XFER_CNT);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if ({bus.DONE, bus.D_READY} !== 2'b01 || bus.XFER_CNT !== 8'd0) begin
            bad++;
            $display("FAIL midrst_nodone DONE,RDY=%b xfer=%0d required 01 0", {bus.DONE, bus.D_READY}, bus.XFER_CNT);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic t, st, ic, qc, q_obs, qbar_obs, pass, mq, exp_err;
        int exp_x, exp_e, gap;
        do_reset(1);
        mq = q_flop;
        exp_x = 0; exp_e = 0; exp_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) bus.D_VALID = 1'b0;
            repeat (gap) @(negedge CLK);
            t  = 1'($urandom);
            st = ($urandom_range(0, 4) == 0);
            ic = ($urandom_range(0, 4) == 0);
            stuck  = st;
            incons = ic;
            qc       = st ? 1'b0 : mq;
            q_obs    = st ? 1'b0 : t;
            qbar_obs = ic ? 1'b1 : ~q_obs;
            pass     = (q_obs == t) && (qbar_obs != q_obs);
            exp_x    = (exp_x < 255) ? exp_x + 1 : 255;
            if (!pass) begin
                exp_e   = (exp_e < 255) ? exp_e + 1 : 255;
                exp_err = 1'b1;
            end
            run_xfer(t, 1'($urandom), o);
            total++;
            if ({o.to, o.s0, o.r0, o.done2, o.match2} !== {1'b0, t & ~qc, ~t & qc, 1'b1, pass}) begin
                bad++;
                $display("FAIL rand[%0d] t=%b qc=%b to,S,R,DONE,MATCH=%b required %b",
                         i, t, qc, {o.to, o.s0, o.r0, o.done2, o.match2}, {1'b0, t & ~qc, ~t & qc, 1'b1, pass});
            end
            total++;
            if (bus.XFER_CNT !== 8'(exp_x) || bus.ERR_CNT !== 8'(exp_e) || bus.ERR !== exp_err) begin
                bad++;
                $display("FAIL rand_cnt[%0d] xfer=%0d err_cnt=%0d err=%b required %0d %0d %b",
                         i, bus.XFER_CNT, bus.ERR_CNT, bus.ERR, exp_x, exp_e, exp_err);
            end
            mq = q_obs;
            stuck  = 1'b0;
            incons = 1'b0;
        end
        bus.D_VALID = 1'b0;
    endtask

    task automatic test_saturation();
        int n, exp_c;
        do_reset(1);
        for (int i = 1; i <= 5; i++) begin
            sbus.D_IN    = 1'b1;
            sbus.D_VALID = 1'b1;
            n = 0;
            while (sbus.D_READY !== 1'b1 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            @(negedge CLK);
            sbus.D_VALID = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            exp_c = (i > 3) ? 3 : i;
            total++;
            if (n >= 20 || {sbus.DONE, sbus.MATCH, sbus.ERR} !== 3'b101 ||
                sbus.ERR_CNT !== 2'(exp_c) || sbus.XFER_CNT !== 2'(exp_c)) begin
                bad++;
                $display("FAIL sat[%0d] wait=%0d DONE,MATCH,ERR=%b err=%0d xfer=%0d required 101 %0d %0d",
                         i, n, {sbus.DONE, sbus.MATCH, sbus.ERR}, sbus.ERR_CNT, sbus.XFER_CNT, exp_c, exp_c);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.D_IN     = 1'b0;
        bus.D_VALID  = 1'b0;
        sbus.D_IN    = 1'b0;
        sbus.D_VALID = 1'b0;
        test_reset();
        test_set();
        test_back_to_back();
        test_stuck();
        test_incons();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
